// File: rtl/y86_seq_controller_if.sv
// Bus between the SEQ sequencer and the fetch/execute/memory/register-file units.
// master = the sequencer, slave = the datapath side that feeds it.
interface y86_seq_controller_if;
  // datapath -> sequencer
  logic        start;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic        cnd;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [63:0] valM;
  logic        imem_error;
  logic        mem_ready;
  logic        dmem_error;
  // sequencer -> datapath
  logic [63:0] pc;
  logic        en_fetch;
  logic        en_decode;
  logic        en_execute;
  logic        en_memory;
  logic        en_writeback;
  logic        mem_req;
  logic        rf_we_E;
  logic        rf_we_M;
  logic [2:0]  stat;
  logic        busy;
  logic [31:0] instr_count;

  modport master (
    input  start, icode, ifun, cnd, valC, valP, valM, imem_error, mem_ready, dmem_error,
    output pc, en_fetch, en_decode, en_execute, en_memory, en_writeback,
           mem_req, rf_we_E, rf_we_M, stat, busy, instr_count
  );

  modport slave (
    output start, icode, ifun, cnd, valC, valP, valM, imem_error, mem_ready, dmem_error,
    input  pc, en_fetch, en_decode, en_execute, en_memory, en_writeback,
           mem_req, rf_we_E, rf_we_M, stat, busy, instr_count
  );
endinterface

// File: rtl/y86_seq_controller.sv
// Multi-cycle sequencer for the SEQ Y86-64 datapath. Walks each instruction
// through FETCH..PCUPDATE, owns the PC, gates register-file writes, handshakes
// with data memory and tracks the architectural status code.
// All outputs are registered: each *_d is derived from the next state so the
// *_q value lines up with the state it describes.
module y86_seq_controller #(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  y86_seq_controller_if.master  bus
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Last MEMORY-cycle index that may still complete; the counter holds the
  // number of MEMORY cycles already spent waiting.
  localparam logic [3:0] TMO_LAST = 4'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPDATE,
    S_HALTED,
    S_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  stat_q, stat_d;
  logic [3:0]  icode_q, icode_d;
  logic        cnd_q, cnd_d;
  logic [63:0] valm_q, valm_d;
  logic [3:0]  tmo_q, tmo_d;
  logic [31:0] count_q, count_d;
  logic        en_fetch_q, en_fetch_d;
  logic        en_decode_q, en_decode_d;
  logic        en_execute_q, en_execute_d;
  logic        en_memory_q, en_memory_d;
  logic        en_writeback_q, en_writeback_d;
  logic        mem_req_q, mem_req_d;
  logic        rf_we_e_q, rf_we_e_d;
  logic        rf_we_m_q, rf_we_m_d;
  logic        busy_q, busy_d;

  // ifun is decoded by the datapath, not here
  logic unused_ifun;
  assign unused_ifun = ^bus.ifun;

  // rmmovq, mrmovq, call, ret, pushq, popq touch data memory
  function automatic logic is_mem_op(input logic [3:0] ic);
    return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  // valE goes to dstE for these; cmovXX only when its condition held
  function automatic logic writes_e(input logic [3:0] ic, input logic c);
    return (ic inside {4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) || (ic == 4'h2 && c);
  endfunction

  // Next-state, datapath latches and registered-output computation
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    icode_d = icode_q;
    cnd_d   = cnd_q;
    valm_d  = valm_q;
    tmo_d   = tmo_q;
    count_d = count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.imem_error) begin
          state_d = S_FAULT;
          stat_d  = STAT_ADR;
        end else if (bus.icode > 4'hB) begin
          state_d = S_FAULT;
          stat_d  = STAT_INS;
        end else if (bus.icode == 4'h0) begin
          // halt retires but leaves pc on the halt instruction
          state_d = S_HALTED;
          stat_d  = STAT_HLT;
          count_d = count_q + 32'd1;
        end else begin
          icode_d = bus.icode;
          cnd_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        cnd_d   = bus.cnd;
        tmo_d   = 4'd0;
        state_d = S_MEMORY;
      end
      S_MEMORY: begin
        if (!is_mem_op(icode_q)) begin
          state_d = S_WRITEBACK;
        end else if (bus.mem_ready) begin
          if (bus.dmem_error) begin
            state_d = S_FAULT;
            stat_d  = STAT_ADR;
          end else begin
            valm_d  = bus.valM;
            state_d = S_WRITEBACK;
          end
        end else if (tmo_q >= TMO_LAST) begin
          state_d = S_FAULT;
          stat_d  = STAT_ADR;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      S_WRITEBACK: begin
        state_d = S_PCUPDATE;
      end
      S_PCUPDATE: begin
        case (icode_q)
          4'h7:    pc_d = cnd_q ? bus.valC : bus.valP;
          4'h8:    pc_d = bus.valC;
          4'h9:    pc_d = valm_q;
          default: pc_d = bus.valP;
        endcase
        count_d = count_q + 32'd1;
        state_d = S_FETCH;
      end
      default: begin
        // HALTED and FAULT are sticky until reset
        state_d = state_q;
      end
    endcase

    en_fetch_d     = (state_d == S_FETCH);
    en_decode_d    = (state_d == S_DECODE);
    en_execute_d   = (state_d == S_EXECUTE);
    en_memory_d    = (state_d == S_MEMORY);
    en_writeback_d = (state_d == S_WRITEBACK);
    mem_req_d      = (state_d == S_MEMORY) && is_mem_op(icode_d);
    rf_we_e_d      = (state_d == S_WRITEBACK) && writes_e(icode_d, cnd_d);
    rf_we_m_d      = (state_d == S_WRITEBACK) && (icode_d == 4'h5 || icode_d == 4'hB);
    busy_d         = (state_d inside {S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY,
                                      S_WRITEBACK, S_PCUPDATE});
  end

  // State and output registers; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      stat_q         <= STAT_AOK;
      icode_q        <= 4'h0;
      cnd_q          <= 1'b0;
      valm_q         <= 64'd0;
      tmo_q          <= 4'd0;
      count_q        <= 32'd0;
      en_fetch_q     <= 1'b0;
      en_decode_q    <= 1'b0;
      en_execute_q   <= 1'b0;
      en_memory_q    <= 1'b0;
      en_writeback_q <= 1'b0;
      mem_req_q      <= 1'b0;
      rf_we_e_q      <= 1'b0;
      rf_we_m_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      stat_q         <= stat_d;
      icode_q        <= icode_d;
      cnd_q          <= cnd_d;
      valm_q         <= valm_d;
      tmo_q          <= tmo_d;
      count_q        <= count_d;
      en_fetch_q     <= en_fetch_d;
      en_decode_q    <= en_decode_d;
      en_execute_q   <= en_execute_d;
      en_memory_q    <= en_memory_d;
      en_writeback_q <= en_writeback_d;
      mem_req_q      <= mem_req_d;
      rf_we_e_q      <= rf_we_e_d;
      rf_we_m_q      <= rf_we_m_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.stat         = stat_q;
  assign bus.instr_count  = count_q;
  assign bus.en_fetch     = en_fetch_q;
  assign bus.en_decode    = en_decode_q;
  assign bus.en_execute   = en_execute_q;
  assign bus.en_memory    = en_memory_q;
  assign bus.en_writeback = en_writeback_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.rf_we_E      = rf_we_e_q;
  assign bus.rf_we_M      = rf_we_m_q;
  assign bus.busy         = busy_q;

endmodule

// File: doc/y86_seq_controller.md
Name: y86_seq_controller

Overview:
- Multi-cycle sequencer for the SEQ Y86-64 datapath. The fetch, decode/register-file, execute, memory and writeback units already exist.
- It owns the architectural PC and steps one instruction through FETCH→DECODE→EXECUTE→MEMORY→WRITEBACK→PCUPDATE with one-hot stage enables.
- It handshakes with data memory, gates register-file writes, computes the new PC, and tracks Y86 status (AOK/HLT/ADR/INS).

Parameters:
- RESET_PC, 0, PC value loaded on reset.
- MEM_TIMEOUT, 15, max cycles waiting for mem_ready before flagging ADR (4-bit counter; range 1–15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin execution from IDLE; ignored in all other states.
- icode  in  4  from fetch, valid while en_fetch is high and held by fetch thereafter.
- ifun  in  4  from fetch (passed through; not decoded here).
- cnd  in  1  condition result from execute, valid in EXECUTE.
- valC  in  64  constant word from fetch.
- valP  in  64  incremented PC from fetch.
- valM  in  64  memory read data, valid when mem_ready.
- imem_error  in  1  fetch address error, sampled in FETCH.
- mem_ready  in  1  data-memory access complete.
- dmem_error  in  1  data-memory error, qualified by mem_ready.
- pc  out  64  current PC driven to fetch.
- en_fetch, en_decode, en_execute, en_memory, en_writeback  out  1 each  one-hot stage enables.
- mem_req  out  1  data-memory request, held high until mem_ready.
- rf_we_E  out  1  write valE to dstE.
- rf_we_M  out  1  write valM to dstM.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- busy  out  1  high in FETCH..PCUPDATE.
- instr_count  out  32  retired instructions; wraps to 0 after 0xFFFFFFFF.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, pc=RESET_PC, stat=1.
  - All enables, mem_req, rf_we_*, busy = 0; instr_count=0; timeout counter=0.
  - Reset mid-instruction aborts immediately; no write enables are issued.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, HALTED, FAULT. Outputs are registered.
- IDLE: start=1 → FETCH.
- FETCH (en_fetch=1, 1 cycle):
  - imem_error → FAULT, stat=3.
  - icode>4'hB → FAULT, stat=4.
  - icode=0 → HALTED, stat=2, pc unchanged; halt counts as retired, instr_count+1.
  - Otherwise latch icode, cnd slot cleared → DECODE.
- DECODE (en_decode=1, 1 cycle) → EXECUTE.
- EXECUTE (en_execute=1, 1 cycle): latch cnd → MEMORY.
- MEMORY (en_memory=1):
  - icode ∈ {4,5,8,9,A,B}: assert mem_req from entry and count cycles.
    - mem_ready & !dmem_error: latch valM → WRITEBACK, mem_req drops the same edge.
    - mem_ready & dmem_error → FAULT, stat=3.
    - Counter reaches MEM_TIMEOUT without mem_ready → FAULT, stat=3.
  - Other icodes: 1 cycle, no mem_req.
- WRITEBACK (en_writeback=1, 1 cycle):
  - rf_we_E=1 for icode ∈ {3,6,8,9,A,B}, and for 2 only if latched cnd=1.
  - rf_we_M=1 for icode ∈ {5,B}.
  - Write enables are 1-cycle pulses, only in this state.
- PCUPDATE (1 cycle), then FETCH:
  - pc ← valC for icode 8.
  - pc ← (cnd ? valC : valP) for icode 7.
  - pc ← latched valM for icode 9.
  - pc ← valP otherwise.
  - instr_count+1.
- Latency: non-memory instruction = 6 cycles/instruction. Memory instruction = 5 + memory cycles (minimum 6 when mem_ready arrives in the first MEMORY cycle).
- HALTED and FAULT:
  - Sticky until reset; start ignored; pc holds the faulting/halting instruction address; busy=0.
- Arithmetic: 64-bit PC, no overflow detection (natural wrap).

Test Plan:
- Reset/start: rst_n low mid-EXECUTE → pc=RESET_PC, stat=1, all enables 0 asynchronously. Release, start=1 → en_fetch high the next cycle.
- irmovq (icode=3, valP=10): enables walk F,D,E,M,W over 5 cycles; rf_we_E pulses once in W, rf_we_M=0; pc=10 and instr_count=1 after PCUPDATE.
- jXX (icode=7, valC=0x40, valP=9): cnd=1 → pc=0x40; repeat with cnd=0 → pc=9. call (8) → pc=valC. ret (9) with mem_ready after 3 cycles, valM=0x100 → mem_req high 3 cycles, pc=0x100, rf_we_E=1.
- mrmovq (5), mem_ready never asserted, MEM_TIMEOUT=15 → FAULT after 15 MEMORY cycles; stat=3, mem_req drops, no rf writes, pc unchanged.
- icode=0 → HALTED, stat=2, instr_count incremented. icode=0xC → FAULT, stat=4. imem_error=1 in FETCH → stat=3. In all three, a later start pulse has no effect.
- cmovXX (icode=2) with cnd=0 → rf_we_E stays 0 throughout WRITEBACK; pc=valP.
